// File: rtl/ub_affine_loop_ctrl_if.sv
// ub_affine_loop_ctrl_if
// Control/status bundle between a unified-buffer port sequencer and its
// environment.
//   flush     : synchronous clear, abandons any pass in progress
//   start     : one-cycle pulse that begins a loop-nest pass
//   stall     : downstream hold (exists only when UB_CTRL_STALL_EN is defined)
//   en        : port enable, wired to the buffer's wen or ren
//   ctrl_vars : iteration vector, [0]=d0 (outer), [1]=d1, [2]=d2 (inner)
//   busy      : high from start acceptance through the last issue
//   done      : one-cycle pulse after the last issue
// Modports: master = environment driving start/flush, slave = the sequencer.
interface ub_affine_loop_ctrl_if;
  logic              flush;
  logic              start;
`ifdef UB_CTRL_STALL_EN
  logic              stall;
`endif
  logic              en;
  logic [2:0][15:0]  ctrl_vars;
  logic              busy;
  logic              done;

  modport master (
`ifdef UB_CTRL_STALL_EN
    output stall,
`endif
    output flush, start,
    input  en, ctrl_vars, busy, done
  );

  modport slave (
`ifdef UB_CTRL_STALL_EN
    input  stall,
`endif
    input  flush, start,
    output en, ctrl_vars, busy, done
  );
endinterface

// File: rtl/ub_affine_loop_ctrl.sv
// ub_affine_loop_ctrl
// Sequencer for one unified-buffer port. Walks a 3-deep affine loop nest
// (d0 outer, d1 middle, d2 inner), issuing one enable per iteration every II
// cycles after an optional START_DELAY idle window.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : ub_affine_loop_ctrl_if.slave (flush, start, [stall], en,
//          ctrl_vars, busy, done)
// Optional feature: define UB_CTRL_STALL_EN to add the stall input. While
// stall is high in DELAY/RUN the whole sequencer freezes and en is gated low.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a pass
// DELAY | counting START_DELAY cycles before the first issue
// RUN   | issuing iterations, one every II cycles
module ub_affine_loop_ctrl #(
  parameter int EXT0        = 1,
  parameter int EXT1        = 62,
  parameter int EXT2        = 62,
  parameter int II          = 1,
  parameter int START_DELAY = 0
) (
  input logic                 clk,
  input logic                 rst,
  ub_affine_loop_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  localparam logic [15:0] L0     = 16'(EXT0 - 1);
  localparam logic [15:0] L1     = 16'(EXT1 - 1);
  localparam logic [15:0] L2     = 16'(EXT2 - 1);
  localparam logic [15:0] II_LD  = 16'(II - 1);
  localparam logic [15:0] DLY_LD = 16'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  state_t      state;
  logic [15:0] dly_cnt;
  logic [15:0] ii_cnt;
  logic [15:0] d0, d1, d2;
  logic        en_q, busy_q, done_q;
  logic        is_last;
  logic        hold;

  // In RUN the vector only reaches the final tuple during its own issue
  // cycle, because the pass ends on the very next edge.
  assign is_last = (d0 == L0) && (d1 == L1) && (d2 == L2);

`ifdef UB_CTRL_STALL_EN
  assign hold   = bus.stall && (state != IDLE);
  assign bus.en = en_q & ~bus.stall;
`else
  assign hold   = 1'b0;
  assign bus.en = en_q;
`endif

  assign bus.ctrl_vars = {d2, d1, d0};
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dly_cnt <= '0;
      ii_cnt  <= '0;
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.flush) begin
      state   <= IDLE;
      dly_cnt <= '0;
      ii_cnt  <= '0;
      d0      <= '0;
      d1      <= '0;
      d2      <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!hold) begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (START_DELAY > 0) begin
              state   <= DELAY;
              dly_cnt <= DLY_LD;
            end else begin
              // first iteration (0,0,0) issues on the acceptance edge
              state  <= RUN;
              en_q   <= 1'b1;
              ii_cnt <= II_LD;
            end
          end
        end
        DELAY: begin
          if (dly_cnt == '0) begin
            state  <= RUN;
            en_q   <= 1'b1;
            ii_cnt <= II_LD;
          end else begin
            dly_cnt <= dly_cnt - 16'd1;
          end
        end
        RUN: begin
          if (is_last) begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            ii_cnt <= '0;
            d0     <= '0;
            d1     <= '0;
            d2     <= '0;
          end else if (ii_cnt == '0) begin
            en_q   <= 1'b1;
            ii_cnt <= II_LD;
            if (d2 == L2) begin
              d2 <= '0;
              if (d1 == L1) begin
                d1 <= '0;
                d0 <= d0 + 16'd1;
              end else begin
                d1 <= d1 + 16'd1;
              end
            end else begin
              d2 <= d2 + 16'd1;
            end
          end else begin
            en_q   <= 1'b0;
            ii_cnt <= ii_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
